manchester_xmit: RTL and testbench
==================================

MANCHESTER_XMIT -- requirements
Module: manchester_xmit

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 50_000, meaning line bit rate in bits/s; HALF_BIT = CLK_FREQ/(2*BIT_RATE) clocks, integer and >= 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port data  input  8  byte offered by the transmit controller.
REQ-006 SHALL have port valid  input  1  data is valid this cycle.
REQ-007 SHALL have port rdy  output  1  holding register can accept a byte this cycle.
REQ-008 SHALL have port txd  output  1  Manchester line output; idle level 1.
REQ-009 SHALL have port txen  output  1  frame in progress, including EOF.
REQ-010 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SEND, EOF.
REQ-012 SHALL accept a byte on a clock edge where valid && rdy; no other edge accepts data.
REQ-013 SHALL drive rdy = 1 in IDLE and in SEND while the 8-bit holding register is empty, and rdy = 0 in EOF.
REQ-014 SHALL, on acceptance in IDLE, load the byte directly into the shifter, enter SEND, clear the half-bit counter, and drive the first half of bit 0 on txd in the next cycle (latency 1 clock).
REQ-015 SHALL, on acceptance in SEND, store the byte in the holding register; rdy falls on the following cycle.
REQ-016 SHALL serialise LSB first, each bit lasting 2*HALF_BIT clocks.
REQ-017 SHALL encode bit 1 as low then high and bit 0 as high then low, each half lasting exactly HALF_BIT clocks.
REQ-018 SHALL, at the end of bit 7, reload the shifter from the holding register with no gap if it is full, marking the holding register empty on that same edge.
REQ-019 SHALL, at the end of bit 7 with the holding register empty, enter EOF.
REQ-020 SHALL, in EOF, drive txd = 1 and txen = 1 for 4*HALF_BIT clocks, then enter IDLE.
REQ-021 SHALL, when valid is asserted on the same edge that bit 7 ends with the holding register empty, accept the byte (rdy was 1), load it into the shifter, and remain in SEND without entering EOF.
REQ-022 SHALL, in IDLE, drive txd = 1 and txen = 0.
REQ-023 SHALL drive txen = 1 in SEND and in EOF.
REQ-024 SHALL wrap the half-bit counter modulo HALF_BIT and the bit counter modulo 8; counter widths are $clog2(HALF_BIT) bits and 3 bits respectively.

Reset
REQ-025 SHALL, while rst = 1 and regardless of clk, force state = IDLE, txd = 1, txen = 0, rdy = 1, busy = 0, clear the holding register and all counters, and discard any partially sent byte.
REQ-026 SHALL accept a byte on the first clock edge after rst is released.

Structure
REQ-027 SHALL take the state enum (mx_state_t) and the constant EOF_HALF_BITS = 4 from shared package mx_pkg.
REQ-028 SHALL contain one sub-module, mx_tick_gen, which produces a single-cycle half-bit tick every HALF_BIT clocks and is cleared synchronously when a frame starts.
REQ-029 SHALL register txd and txen; they SHALL NOT be combinational outputs.

Verification (bench uses CLK_FREQ = 800, BIT_RATE = 50, giving HALF_BIT = 8)
REQ-030 SHALL cover: single byte 0xA5 in IDLE -> txd from the next cycle is 8-clock halves encoding bits 1,0,1,0,0,1,0,1 (LSB first), then 32 clocks of txd = 1 with txen = 1, then txen = 0 and busy = 0.
REQ-031 SHALL cover: bytes 0x00 then 0xFF, with the second offered during the first -> 256 contiguous clocks of Manchester data with no idle gap, and rdy low from one cycle after the second acceptance until the reload edge.
REQ-032 SHALL cover: valid held high with rdy = 0 -> no byte lost or duplicated; the sequence 0x01, 0x02, 0x03 appears on txd in order.
REQ-033 SHALL cover: valid asserted during EOF -> rdy = 0 and the byte is not taken; the byte is accepted in IDLE after EOF and forms a new frame.
REQ-034 SHALL cover: rst asserted mid-byte, asynchronous to clk -> txd = 1 and txen = 0 immediately; byte 0x3C sent after release is transmitted intact.
REQ-035 SHALL cover: valid on the exact bit-7 end edge with the holding register empty -> no EOF is inserted and 0x55 follows without a gap.

Source files
------------

// File: rtl/mx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mx_pkg
// Purpose : Shared types and constants for the Manchester transmitter.
//           Provides the FSM state enum, the end-of-frame length in half-bit
//           periods, and the line-level encoding helper.
// Revision: 1.0 - initial release
// ============================================================================
package mx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        EOF  = 2'd2
    } mx_state_t;

    // Length of the end-of-frame marker, in half-bit periods.
    localparam int EOF_HALF_BITS = 4;
    localparam int BITS_PER_BYTE = 8;

    // Manchester line level for one data bit: a 1 is sent low then high,
    // a 0 is sent high then low.
    function automatic logic mx_level(input logic bit_val, input logic second_half);
        return second_half ? bit_val : ~bit_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mx_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : mx_tick_gen
// Purpose : Half-bit timebase. Emits a single-cycle tick every HALF_BIT
//           enabled clocks; a synchronous clear restarts the period so that
//           a new frame begins exactly on a half-bit boundary.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset
//           clr  - synchronous counter clear (frame start)
//           en   - count enable
//           tick - one-cycle pulse on the last clock of each half-bit period
// Revision: 1.0 - initial release
// ============================================================================
module mx_tick_gen #(
    parameter int HALF_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            c_cw   = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(HALF_BIT - 1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/manchester_xmit.sv
`default_nettype none
// ============================================================================
// Module  : manchester_xmit
// Purpose : Byte-wide Manchester transmitter with a one-byte holding
//           register. Bytes are sent LSB first; back-to-back bytes follow
//           without a gap. Each frame ends with an EOF marker of
//           EOF_HALF_BITS half-bit periods of idle-high line with txen held.
// Ports   : clk   - clock, all state updates on the rising edge
//           rst   - asynchronous active-high reset
//           data  - byte offered by the transmit controller
//           valid - data is valid this cycle
//           rdy   - a byte can be accepted this cycle
//           txd   - Manchester line output (idle high), registered
//           txen  - frame in progress including EOF, registered
//           busy  - state is not IDLE
// Revision: 1.0 - initial release
// ============================================================================
module manchester_xmit
    import mx_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BIT_RATE = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       rdy,
    output logic       txd,
    output logic       txen,
    output logic       busy
);

    localparam int              HALF_BIT   = CLK_FREQ / (2 * BIT_RATE);
    localparam int              c_eof_cw   = $clog2(EOF_HALF_BITS);
    localparam logic [c_eof_cw-1:0] c_eof_last = c_eof_cw'(EOF_HALF_BITS - 1);
    localparam logic [2:0]      c_last_bit = 3'(BITS_PER_BYTE - 1);

    mx_state_t             r_state, w_state_d;
    logic [7:0]            r_shift, w_shift_d;
    logic [7:0]            r_hold,  w_hold_d;
    logic                  r_hold_full, w_hold_full_d;
    logic [2:0]            r_bit_cnt, w_bit_cnt_d;
    logic                  r_half, w_half_d;       // 0: first half, 1: second half
    logic [c_eof_cw-1:0]   r_eof_cnt, w_eof_cnt_d;
    logic                  r_txd, r_txen;

    logic                  w_tick;
    logic                  w_start;
    logic                  w_byte_end;
    logic                  w_accept;

    // ------------------------------------------------------------------
    // Half-bit timebase, restarted on the edge that starts a frame.
    // ------------------------------------------------------------------
    assign w_start = (r_state == IDLE) && valid;

    mx_tick_gen #(
        .HALF_BIT (HALF_BIT)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start),
        .en   (r_state != IDLE),
        .tick (w_tick)
    );

    assign w_accept   = valid && rdy;
    // Last clock of the second half of bit 7.
    assign w_byte_end = (r_state == SEND) && w_tick && r_half && (r_bit_cnt == c_last_bit);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_state_d = SEND;
                end
            end
            SEND: begin
                // A byte offered on the byte-end edge keeps the frame open.
                if (w_byte_end && !r_hold_full && !valid) begin
                    w_state_d = EOF;
                end
            end
            EOF: begin
                if (w_tick && (r_eof_cnt == c_eof_last)) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rdy  = 1'b0;
        busy = 1'b1;
        case (r_state)
            IDLE: begin
                rdy  = 1'b1;
                busy = 1'b0;
            end
            SEND:    rdy = !r_hold_full;
            EOF:     rdy = 1'b0;
            default: rdy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: shifter, holding register, counters
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_d     = r_shift;
        w_hold_d      = r_hold;
        w_hold_full_d = r_hold_full;
        w_bit_cnt_d   = r_bit_cnt;
        w_half_d      = r_half;
        w_eof_cnt_d   = '0;
        case (r_state)
            IDLE: begin
                w_bit_cnt_d = '0;
                w_half_d    = 1'b0;
                if (valid) begin
                    w_shift_d = data;
                end
            end
            SEND: begin
                // On the byte-end edge with an empty holding register the
                // byte goes straight into the shifter instead.
                if (w_accept && !w_byte_end) begin
                    w_hold_d      = data;
                    w_hold_full_d = 1'b1;
                end
                if (w_tick) begin
                    w_half_d = ~r_half;
                    if (r_half) begin
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            if (r_hold_full) begin
                                w_shift_d     = r_hold;
                                w_hold_full_d = 1'b0;
                            end else if (valid) begin
                                w_shift_d = data;
                            end
                        end else begin
                            w_shift_d = {1'b0, r_shift[7:1]};
                        end
                    end
                end
            end
            EOF: begin
                w_eof_cnt_d = w_tick ? r_eof_cnt + 1'b1 : r_eof_cnt;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. txd/txen are registered from the next-state
    // values so the line changes on the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_half      <= 1'b0;
            r_eof_cnt   <= '0;
            r_txd       <= 1'b1;
            r_txen      <= 1'b0;
        end else begin
            r_shift     <= w_shift_d;
            r_hold      <= w_hold_d;
            r_hold_full <= w_hold_full_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_half      <= w_half_d;
            r_eof_cnt   <= w_eof_cnt_d;
            r_txd       <= (w_state_d == SEND) ? mx_level(w_shift_d[0], w_half_d) : 1'b1;
            r_txen      <= (w_state_d != IDLE);
        end
    end

    assign txd  = r_txd;
    assign txen = r_txen;

endmodule
`default_nettype wire

// File: tb/tb_manchester_xmit.sv
`default_nettype none
// ============================================================================
// Module  : tb_manchester_xmit
// Purpose : Self-checking bench for manchester_xmit. Expected line activity
//           is generated from the encoding rules (bit order, half-bit levels,
//           EOF length) and compared cycle by cycle with txd/txen.
// Revision: 1.0 - initial release
// ============================================================================
module tb_manchester_xmit;

    localparam int HB = 8;   // 800 Hz / (2 * 50 b/s)

    typedef logic [7:0] byte_q_t[$];
    typedef logic [1:0] lvl_q_t[$];   // {txen, txd} per cycle
    typedef int         int_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    wire        rdy;
    wire        txd;
    wire        txen;
    wire        busy;

    int errors = 0;
    int checks = 0;

    manchester_xmit #(
        .CLK_FREQ (800),
        .BIT_RATE (50)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .rdy   (rdy),
        .txd   (txd),
        .txen  (txen),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: contiguous bytes, LSB first, 1 = low/high, 0 = high/low,
    // then 4 half-bits of high line with txen, then idle cycles.
    function automatic lvl_q_t model_stream(input byte_q_t bytes, input int idle_after);
        lvl_q_t     q;
        logic [7:0] b;
        foreach (bytes[k]) begin
            b = bytes[k];
            for (int i = 0; i < 8; i++) begin
                repeat (HB) q.push_back({1'b1, ~b[i]});
                repeat (HB) q.push_back({1'b1,  b[i]});
            end
        end
        repeat (4 * HB) q.push_back(2'b11);
        repeat (idle_after) q.push_back(2'b01);
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers each byte after gaps[k] idle cycles, holding valid until taken.
    task automatic drive(input byte_q_t bytes, input int_q_t gaps);
        logic acc;
        foreach (bytes[k]) begin
            repeat (gaps[k]) step();
            valid = 1'b1;
            data  = bytes[k];
            acc   = 1'b0;
            for (int t = 0; t < 400 && !acc; t++) begin
                acc = rdy;
                step();
            end
            valid = 1'b0;
            data  = 8'($urandom);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL drive_accept: byte %02h not taken, accepted=%b want 1", bytes[k], acc);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        #2;
        checks++; if (txd  !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd);  end
        checks++; if (txen !== 1'b0) begin errors++; $display("FAIL reset_txen: got %b want 0", txen); end
        checks++; if (rdy  !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy);  end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_a5();
        lvl_q_t exp;
        exp = model_stream('{8'hA5}, 2);
        fork
            drive('{8'hA5}, '{0});
            for (int i = 0; i < exp.size(); i++) begin
                step();
                checks++;
                if ({txen, txd} !== exp[i]) begin
                    errors++;
                    $display("FAIL a5_line cyc %0d: txen,txd=%b want %b", i, {txen, txd}, exp[i]);
                end
                checks++;
                if (busy !== exp[i][1]) begin
                    errors++;
                    $display("FAIL a5_busy cyc %0d: got %b want %b", i, busy, exp[i][1]);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        lvl_q_t exp;
        logic   exp_rdy;
        exp = model_stream('{8'h00, 8'hFF}, 2);
        fork
            drive('{8'h00, 8'hFF}, '{0, 20});
            for (int i = 0; i < exp.size(); i++) begin
                step();
                // Second byte is taken on edge 21 and reloaded on edge 128.
                exp_rdy = !((i >= 21 && i < 128) || (i >= 256 && i < 256 + 4 * HB));
                checks++;
                if ({txen, txd} !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_line cyc %0d: txen,txd=%b want %b", i, {txen, txd}, exp[i]);
                end
                checks++;
                if (rdy !== exp_rdy) begin
                    errors++;
                    $display("FAIL b2b_rdy cyc %0d: got %b want %b", i, rdy, exp_rdy);
                end
            end
        join
    endtask

    task automatic test_valid_held();
        lvl_q_t exp;
        exp = model_stream('{8'h01, 8'h02, 8'h03}, 2);
        fork
            drive('{8'h01, 8'h02, 8'h03}, '{0, 0, 0});
            for (int i = 0; i < exp.size(); i++) begin
                step();
                checks++;
                if ({txen, txd} !== exp[i]) begin
                    errors++;
                    $display("FAIL held_line cyc %0d: txen,txd=%b want %b", i, {txen, txd}, exp[i]);
                end
            end
        join
    endtask

    task automatic test_eof_offer();
        lvl_q_t     exp, tail;
        logic [7:0] x, y;
        x    = 8'($urandom);
        y    = 8'($urandom);
        exp  = model_stream('{x}, 1);
        tail = model_stream('{y}, 2);
        foreach (tail[i]) exp.push_back(tail[i]);
        fork
            drive('{x, y}, '{0, 132});
            for (int i = 0; i < exp.size(); i++) begin
                step();
                checks++;
                if ({txen, txd} !== exp[i]) begin
                    errors++;
                    $display("FAIL eof_line cyc %0d: txen,txd=%b want %b", i, {txen, txd}, exp[i]);
                end
                if (i >= 128 && i < 128 + 4 * HB) begin
                    checks++;
                    if (rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL eof_rdy cyc %0d: got %b want 0", i, rdy);
                    end
                end
            end
        join
    endtask

    task automatic test_async_reset();
        lvl_q_t exp;
        valid = 1'b1;
        data  = 8'($urandom);
        step();
        valid = 1'b0;
        repeat (40) step();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (txd  !== 1'b1) begin errors++; $display("FAIL arst_txd: got %b want 1", txd);  end
        checks++; if (txen !== 1'b0) begin errors++; $display("FAIL arst_txen: got %b want 0", txen); end
        checks++; if (rdy  !== 1'b1) begin errors++; $display("FAIL arst_rdy: got %b want 1", rdy);  end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        step();
        rst   = 1'b0;
        valid = 1'b1;
        data  = 8'h3C;
        exp   = model_stream('{8'h3C}, 2);
        for (int i = 0; i < exp.size(); i++) begin
            step();
            valid = 1'b0;
            checks++;
            if ({txen, txd} !== exp[i]) begin
                errors++;
                $display("FAIL arst_3c_line cyc %0d: txen,txd=%b want %b", i, {txen, txd}, exp[i]);
            end
        end
    endtask

    task automatic test_bit7_edge();
        lvl_q_t     exp;
        logic [7:0] x;
        x   = 8'($urandom);
        exp = model_stream('{x, 8'h55}, 2);
        fork
            drive('{x, 8'h55}, '{0, 127});
            for (int i = 0; i < exp.size(); i++) begin
                step();
                checks++;
                if ({txen, txd} !== exp[i]) begin
                    errors++;
                    $display("FAIL edge_line cyc %0d: txen,txd=%b want %b", i, {txen, txd}, exp[i]);
                end
            end
        join
    endtask

    task automatic test_random();
        lvl_q_t  exp;
        byte_q_t bytes;
        int_q_t  gaps;
        int      n;
        for (int it = 0; it < 4; it++) begin
            bytes.delete();
            gaps.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                bytes.push_back(8'($urandom));
                gaps.push_back(k == 0 ? 0 : $urandom_range(0, 100));
            end
            exp = model_stream(bytes, 2);
            fork
                drive(bytes, gaps);
                for (int i = 0; i < exp.size(); i++) begin
                    step();
                    checks++;
                    if ({txen, txd} !== exp[i]) begin
                        errors++;
                        $display("FAIL rand%0d_line cyc %0d: txen,txd=%b want %b", it, i, {txen, txd}, exp[i]);
                    end
                end
            join
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_busy_end: got %b want 0", it, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_valid_held();
        test_eof_offer();
        test_async_reset();
        test_bit7_edge();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
